// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel_pipeline stream blocks.
package sobel_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DONE    = 2'd2
  } capture_state_e;

  localparam int unsigned CHECKSUM_W = 32;

  function automatic int unsigned PIXEL_W(input int unsigned channels);
    return channels * 8;
  endfunction

endpackage

// File: rtl/pixel_checksum.sv
// Wrapping 32-bit sum of every channel byte of each enabled pixel.
module pixel_checksum
  import sobel_pkg::*;
#(
  parameter int unsigned CHANNELS_P = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              clear_i,
  input  logic                              en_i,
  input  logic [PIXEL_W(CHANNELS_P)-1:0]    pixel_i,
  output logic [CHECKSUM_W-1:0]             sum_o
);

  logic [CHECKSUM_W-1:0] sum_q, sum_d;
  logic [CHECKSUM_W-1:0] byte_sum;

  always_comb begin
    byte_sum = '0;
    for (int unsigned c = 0; c < CHANNELS_P; c++) begin
      byte_sum = byte_sum + CHECKSUM_W'(pixel_i[c*8 +: 8]);
    end
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + byte_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/frame_capture.sv
// Stream sink writing one frame row-major into frame memory, with framing check.
// Optional checksum accumulator enabled by FRAME_CAPTURE_CHECKSUM_EN.
module frame_capture
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P    = 640,
  parameter int unsigned HEIGHT_P   = 480,
  parameter int unsigned CHANNELS_P = 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic [PIXEL_W(CHANNELS_P)-1:0]         pixel_i,
  input  logic                                   last_i,
  output logic                                   mem_we_o,
  output logic [$clog2(WIDTH_P*HEIGHT_P)-1:0]    mem_addr_o,
  output logic [PIXEL_W(CHANNELS_P)-1:0]         mem_data_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   error_o,
  output logic [CHECKSUM_W-1:0]                  checksum_o
);

  localparam int unsigned N_PIX = WIDTH_P * HEIGHT_P;
  localparam int unsigned AW    = $clog2(WIDTH_P * HEIGHT_P);
  localparam int unsigned PW    = PIXEL_W(CHANNELS_P);

  capture_state_e  state_q, state_d;
  logic [AW-1:0]   count_q, count_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   data_q, data_d;
  logic            we_q, we_d;
  logic            error_q, error_d;
  logic            handshake;
  logic            start_accept;
  logic            at_end;

  assign handshake    = valid_i && (state_q == CAP_CAPTURE);
  assign start_accept = start_i && (state_q == CAP_IDLE);
  assign at_end       = (count_q == AW'(N_PIX - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    we_d    = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (start_accept) begin
          state_d = CAP_CAPTURE;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      CAP_CAPTURE: begin
        if (handshake) begin
          we_d    = 1'b1;
          addr_d  = count_q;
          data_d  = pixel_i;
          count_d = count_q + AW'(1);
          // Clean end needs last and the final address together; either alone is an error.
          if (last_i || at_end) begin
            state_d = CAP_DONE;
            error_d = last_i ^ at_end;
          end
        end
      end
      CAP_DONE: state_d = CAP_IDLE;
      default:  state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CAP_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      error_q <= error_d;
    end
  end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
  pixel_checksum #(
    .CHANNELS_P(CHANNELS_P)
  ) u_checksum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_accept),
    .en_i    (handshake),
    .pixel_i (pixel_i),
    .sum_o   (checksum_o)
  );
`else
  assign checksum_o = '0;
`endif

  assign ready_o    = (state_q == CAP_CAPTURE);
  assign busy_o     = (state_q == CAP_CAPTURE);
  assign done_o     = (state_q == CAP_DONE);
  assign error_o    = error_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture with a 4x2 single-channel frame.
module tb_frame_capture;

  localparam int W = 4;
  localparam int H = 2;
  localparam int C = 1;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  pixel_i = '0;
  logic        last_i = 1'b0;
  logic        mem_we_o;
  logic [2:0]  mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] checksum_o;

  always #5 clk = ~clk;

  frame_capture #(.WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(C)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .valid_i(valid_i),
    .ready_o(ready_o), .pixel_i(pixel_i), .last_i(last_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .checksum_o(checksum_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] stim_pix [16];
  logic       stim_last[16];

  // Observed memory writes and done pulses
  logic [2:0] log_addr[$];
  logic [7:0] log_data[$];
  int   done_cnt = 0;
  int   done_bad = 0;
  int   we_viol = 0;
  logic done_err = 1'b0;
  logic [2:0] done_addr = '0;
  bit   hs_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we_o !== hs_prev) we_viol++;
    if (mem_we_o === 1'b1) begin
      log_addr.push_back(mem_addr_o);
      log_data.push_back(mem_data_o);
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_err  = error_o;
      done_addr = mem_addr_o;
      if (mem_we_o !== 1'b1) done_bad++;
    end
    hs_prev = valid_i & ready_o & ~reset_i;
  end

  // Reference model: frame ends at the first pixel with last or at pixel N
  function automatic int model_len(input int n);
    for (int i = 0; i < n; i++) begin
      if (stim_last[i] || i == N - 1) return i + 1;
    end
    return n;
  endfunction

  function automatic logic model_err(input int len);
    return !(stim_last[len-1] && len == N);
  endfunction

  function automatic logic [31:0] model_sum(input int len);
    logic [31:0] s = '0;
    for (int i = 0; i < len; i++) s = s + 32'(stim_pix[i]);
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    return s;
`else
    return (s & 32'h0);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
    done_bad = 0;
    we_viol  = 0;
  endtask

  task automatic do_reset;
    reset_i = 1'b1; valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
    tick; tick;
    reset_i = 1'b0;
  endtask

  task automatic do_start;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
  endtask

  task automatic fill(input int last_at, input bit ramp);
    for (int i = 0; i < 16; i++) begin
      stim_pix[i]  = ramp ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
      stim_last[i] = (i == last_at);
    end
  endtask

  // mode 0: continuous, 1: valid on alternate cycles, 2: random valid
  task automatic send(input int n, input int mode, output int accepted);
    int idx = 0;
    bit hs;
    for (int cyc = 0; cyc < 40 && idx < n; cyc++) begin
      valid_i = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      pixel_i = stim_pix[idx];
      last_i  = stim_last[idx];
      hs = valid_i && ready_o;
      tick;
      if (hs) idx++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    accepted = idx;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    n_checks++; if ({busy_o, done_o, error_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy_o, done_o, error_o}); end
    n_checks++; if ({mem_addr_o, mem_data_o} !== 11'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h want 0", {mem_addr_o, mem_data_o}); end
    n_checks++; if (checksum_o !== 32'h0) begin n_fail++; $display("FAIL reset_checksum: got %h want 0", checksum_o); end
  endtask

  task automatic test_clean;
    int acc;
    fill(7, 1'b1);
    clear_log;
    do_start;
    n_checks++; if (ready_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL clean_start: got ready=%b busy=%b want 1 1", ready_o, busy_o); end
    send(8, 0, acc);
    n_checks++; if (ready_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL clean_end_cycle: got ready=%b done=%b want 0 1", ready_o, done_o); end
    tick; tick;
    n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL clean_nwrites: got %0d want 8", log_addr.size()); end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      n_checks++; if (log_addr[i] !== 3'(i) || log_data[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL clean_write%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 3'(i), 8'(8'h10 + i)); end
    end
    n_checks++; if (done_cnt != 1 || done_bad != 0 || done_addr !== 3'd7) begin n_fail++; $display("FAIL clean_done: got cnt=%0d bad=%0d addr=%0d want 1 0 7", done_cnt, done_bad, done_addr); end
    n_checks++; if (done_err !== 1'b0 || error_o !== 1'b0) begin n_fail++; $display("FAIL clean_error: got %b/%b want 0", done_err, error_o); end
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    n_checks++; if (checksum_o !== 32'h9C) begin n_fail++; $display("FAIL clean_checksum: got %h want 9c", checksum_o); end
`else
    n_checks++; if (checksum_o !== 32'h0) begin n_fail++; $display("FAIL clean_checksum: got %h want 0", checksum_o); end
`endif
  endtask

  task automatic test_throttled;
    int acc, len;
    fill(7, 1'b0);
    clear_log;
    do_start;
    send(8, 1, acc);
    tick; tick;
    len = model_len(8);
    n_checks++; if (log_addr.size() != len) begin n_fail++; $display("FAIL thr_nwrites: got %0d want %0d", log_addr.size(), len); end
    for (int i = 0; i < log_addr.size() && i < len; i++) begin
      n_checks++; if (log_addr[i] !== 3'(i) || log_data[i] !== stim_pix[i]) begin n_fail++; $display("FAIL thr_write%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 3'(i), stim_pix[i]); end
    end
    n_checks++; if (we_viol != 0) begin n_fail++; $display("FAIL thr_we_follows_hs: got %0d bad cycles want 0", we_viol); end
    n_checks++; if (done_cnt != 1 || done_err !== model_err(len)) begin n_fail++; $display("FAIL thr_done: got cnt=%0d err=%b want 1 %b", done_cnt, done_err, model_err(len)); end
    n_checks++; if (checksum_o !== model_sum(len)) begin n_fail++; $display("FAIL thr_checksum: got %h want %h", checksum_o, model_sum(len)); end
  endtask

  task automatic test_short;
    int acc, len;
    fill(4, 1'b0);
    clear_log;
    do_start;
    send(8, 2, acc);
    len = model_len(8);
    n_checks++; if (acc != len) begin n_fail++; $display("FAIL short_accepted: got %0d want %0d", acc, len); end
    n_checks++; if (log_addr.size() != len) begin n_fail++; $display("FAIL short_nwrites: got %0d want %0d", log_addr.size(), len); end
    for (int i = 0; i < log_addr.size() && i < len; i++) begin
      n_checks++; if (log_addr[i] !== 3'(i) || log_data[i] !== stim_pix[i]) begin n_fail++; $display("FAIL short_write%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 3'(i), stim_pix[i]); end
    end
    n_checks++; if (done_cnt != 1 || done_err !== 1'b1 || error_o !== 1'b1) begin n_fail++; $display("FAIL short_error: got cnt=%0d err=%b/%b want 1 1 1", done_cnt, done_err, error_o); end
    n_checks++; if (checksum_o !== model_sum(len)) begin n_fail++; $display("FAIL short_checksum: got %h want %h", checksum_o, model_sum(len)); end
    do_start;
    n_checks++; if (error_o !== 1'b0 || checksum_o !== 32'h0) begin n_fail++; $display("FAIL short_restart_clear: got err=%b sum=%h want 0 0", error_o, checksum_o); end
    fill(7, 1'b0);
    send(8, 0, acc);
    tick; tick;
  endtask

  task automatic test_missing_last;
    int acc;
    fill(-1, 1'b0);
    clear_log;
    do_start;
    send(10, 0, acc);
    tick; tick;
    n_checks++; if (acc != 8) begin n_fail++; $display("FAIL miss_accepted: got %0d want 8", acc); end
    n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL miss_nwrites: got %0d want 8", log_addr.size()); end
    n_checks++; if (log_data.size() == 8 && log_data[7] !== stim_pix[7]) begin n_fail++; $display("FAIL miss_lastdata: got %h want %h", log_data[7], stim_pix[7]); end
    n_checks++; if (done_cnt != 1 || done_err !== 1'b1 || error_o !== 1'b1) begin n_fail++; $display("FAIL miss_error: got cnt=%0d err=%b/%b want 1 1 1", done_cnt, done_err, error_o); end
  endtask

  task automatic test_reset_mid;
    int acc;
    fill(-1, 1'b0);
    clear_log;
    do_start;
    send(3, 0, acc);
    valid_i = 1'b1;
    reset_i = 1'b1;
    tick;
    n_checks++; if ({ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00000", {ready_o, mem_we_o, busy_o, done_o, error_o}); end
    n_checks++; if ({mem_addr_o, mem_data_o} !== 11'h0 || checksum_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h/%h want 0", {mem_addr_o, mem_data_o}, checksum_o); end
    reset_i = 1'b0;
    valid_i = 1'b0;
    tick;
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d want 0", done_cnt); end
    fill(7, 1'b0);
    clear_log;
    do_start;
    send(8, 0, acc);
    tick; tick;
    n_checks++; if (log_addr.size() != 8 || log_addr[0] !== 3'd0 || log_data[0] !== stim_pix[0]) begin n_fail++; $display("FAIL rstmid_restart: got n=%0d first=%h want 8 writes from 0", log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 3'h7); end
    n_checks++; if (checksum_o !== model_sum(8)) begin n_fail++; $display("FAIL rstmid_checksum: got %h want %h", checksum_o, model_sum(8)); end
  endtask

  task automatic test_ignored;
    int acc;
    clear_log;
    valid_i = 1'b1;
    pixel_i = 8'hAA;
    for (int i = 0; i < 5; i++) tick;
    valid_i = 1'b0;
    tick;
    n_checks++; if (log_addr.size() != 0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL ign_idle_valid: got writes=%0d ready=%b want 0 0", log_addr.size(), ready_o); end
    fill(7, 1'b0);
    start_i = 1'b1;
    tick;
    send(8, 0, acc);
    start_i = 1'b0;
    tick; tick;
    n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL ign_start_nwrites: got %0d want 8", log_addr.size()); end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      n_checks++; if (log_addr[i] !== 3'(i) || log_data[i] !== stim_pix[i]) begin n_fail++; $display("FAIL ign_write%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 3'(i), stim_pix[i]); end
    end
    n_checks++; if (done_cnt != 1 || error_o !== 1'b0) begin n_fail++; $display("FAIL ign_done: got cnt=%0d err=%b want 1 0", done_cnt, error_o); end
  endtask

  task automatic test_back_to_back;
    int acc;
    fill(7, 1'b0);
    clear_log;
    do_start;
    send(8, 0, acc);
    start_i = 1'b1;
    tick;
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got ready=%b want 0", ready_o); end
    tick;
    start_i = 1'b0;
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rearm: got ready=%b want 1", ready_o); end
    fill(7, 1'b0);
    clear_log;
    send(8, 2, acc);
    tick; tick;
    n_checks++; if (log_addr.size() != 8 || done_cnt != 1) begin n_fail++; $display("FAIL b2b_second: got writes=%0d done=%0d want 8 1", log_addr.size(), done_cnt); end
    n_checks++; if (log_data.size() == 8 && log_data[7] !== stim_pix[7]) begin n_fail++; $display("FAIL b2b_lastdata: got %h want %h", log_data[7], stim_pix[7]); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_throttled;
    test_short;
    test_missing_last;
    test_reset_mid;
    test_ignored;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
# frame_capture

Stream-sink block that terminates the `sobel_pipeline` output stream in hardware. It accepts `valid`/`ready` pixels tagged with an end-of-frame `last`, and writes them row-major into a single-port frame memory. It checks frame length against `last` and reports completion and framing errors to a host controller. It is the RTL counterpart of the bench-side pixel capture and sits directly behind `sobel_pipeline`.

## Interface
Parameters:
- `WIDTH_P`, 640: pixels per row.
- `HEIGHT_P`, 480: rows per frame.
- `CHANNELS_P`, 1: 8-bit channels per pixel.

Ports:
- `clk_i`, in, 1: single clock; all logic is on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: arms capture of one frame; honoured only in IDLE.
- `valid_i`, in, 1: input pixel valid.
- `ready_o`, out, 1: block can accept a pixel.
- `pixel_i`, in, `CHANNELS_P*8`: input pixel.
- `last_i`, in, 1: marks the final pixel of the frame.
- `mem_we_o`, out, 1: frame memory write enable.
- `mem_addr_o`, out, `$clog2(WIDTH_P*HEIGHT_P)`: frame memory word address.
- `mem_data_o`, out, `CHANNELS_P*8`: frame memory write data.
- `busy_o`, out, 1: state is CAPTURE.
- `done_o`, out, 1: one-cycle pulse when the frame ends.
- `error_o`, out, 1: sticky framing error.
- `checksum_o`, out, 32: frame checksum (see Configuration).

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - `ready_o`=0.
  - `start_i`=1 moves to CAPTURE and clears the pixel count, `error_o` and `checksum_o`.
- CAPTURE:
  - `ready_o`=1 and `busy_o`=1.
  - A handshake is `valid_i & ready_o`.
  - Each handshake writes the pixel at address = count, then increments count. Count runs 0 to N-1, where N = `WIDTH_P*HEIGHT_P`.
- End of frame: the first handshake where `last_i`=1 or count==N-1 moves the FSM to DONE.
  - `last_i`=1 with count<N-1 (short frame): the pixel is written and `error_o` is set.
  - count==N-1 with `last_i`=0 (missing last): the pixel is written and `error_o` is set.
  - Both conditions together is a clean frame.
- DONE: `done_o`=1 and `ready_o`=0 for exactly one cycle, then IDLE.
- `start_i` in CAPTURE or DONE is ignored.
- `valid_i` outside CAPTURE has no effect.
- Memory never sees an address ≥ N.
- `error_o` holds until the next accepted `start_i` or reset.

## Timing
- Reset values: FSM=IDLE, count=0. `ready_o`, `mem_we_o`, `busy_o`, `done_o` and `error_o` are 0. `mem_addr_o`, `mem_data_o` and `checksum_o` are 0.
- `ready_o` and `busy_o` are decoded from the registered state, with no combinational path from `valid_i`.
- Start: `start_i` sampled at edge E gives `ready_o`=1 from E+1.
- Write latency:
  - A handshake at edge K drives `mem_we_o`=1 with that pixel's address and data for the cycle after K.
  - Back-to-back handshakes produce back-to-back writes.
- End of frame:
  - Final handshake at edge K: the final write and `done_o`=1 are both visible in cycle K+1, and `error_o` is valid in that same cycle.
  - `ready_o`=0 in cycle K+1.
  - IDLE from K+2, so the earliest re-arm is `start_i` at K+2.
- Reset mid-frame: `reset_i` at any edge aborts the frame immediately. Everything goes to reset values with no `done_o` pulse. `mem_we_o`=0 in the next cycle.

## Configuration
- Macro: `FRAME_CAPTURE_CHECKSUM_EN`.
- Defined:
  - `checksum_o` is a 32-bit wrapping sum of every channel byte of every accepted pixel.
  - It is cleared on an accepted `start_i`.
  - It is updated with the same latency as the write, so it is final when `done_o`=1, and holds until the next start.
- Undefined: `checksum_o` is tied to 0 and no accumulator logic is synthesised.

## Structure
- The shared package `sobel_pkg` holds:
  - the FSM state enum `capture_state_e`;
  - the `PIXEL_W` helper (`CHANNELS_P*8`);
  - the `CHECKSUM_W`=32 constant.
- One sub-module: `pixel_checksum`.
  - Ports: clear, enable, pixel in; 32-bit sum out.
  - It is instantiated only under `FRAME_CAPTURE_CHECKSUM_EN`.
- Count and address share one linear counter; there are no multipliers.

## Test plan
All scenarios use `WIDTH_P`=4, `HEIGHT_P`=2 (N=8) and `CHANNELS_P`=1.
- Clean frame:
  - Stimulus: start, then 8 continuous pixels 0x10..0x17, with `last_i` on the 8th.
  - Response: writes to addresses 0..7 with data 0x10..0x17. `done_o` pulses once in the cycle of the address-7 write. `error_o`=0. `checksum_o`=0x9C with the macro, 0 without.
- Throttled input:
  - Stimulus: the same frame with `valid_i` low on alternate cycles.
  - Response: identical write sequence, with `mem_we_o` only in cycles following handshakes.
- Short frame:
  - Stimulus: `last_i` on the 5th pixel.
  - Response: writes to addresses 0..4 only. `done_o` with `error_o`=1. A following start clears `error_o`.
- Missing last:
  - Stimulus: 8 pixels with `last_i` never asserted, then 2 extra pixels.
  - Response: `error_o`=1 and `done_o` after the 8th pixel. The extras are not accepted (`ready_o`=0) and never written.
- Reset mid-frame:
  - Stimulus: `reset_i` after 3 pixels.
  - Response: all outputs at reset values, no `done_o`. A new start plus 8 pixels writes from address 0.
- Ignored inputs:
  - Stimulus: `valid_i`=1 with no start for 5 cycles; `start_i` held high during CAPTURE.
  - Response: no writes in the first case. The count is not restarted in the second case.
